// File: rtl/uni_shift_seq_pkg.sv
// Shared encodings for the universal shift register command sequencer:
// command ops, shift-register mode selects and FSM states.
package usr_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Mode select for a shift op; only ever called with OP_SHR or OP_SHL.
    function automatic sel_e shift_sel(input op_e op);
        return (op == OP_SHL) ? SEL_SHL : SEL_SHR;
    endfunction

endpackage

// File: rtl/uni_shift_seq_shift_cnt.sv
// Loadable down-counter for the number of remaining shift cycles.
// Saturates at zero rather than wrapping.
module shift_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // NOTE: state uses non-blocking assignments and an async active-low clear in the sensitivity list.
    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (load) begin
            count <= din;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uni_shift_seq.sv
// Command sequencer for a 4-bit universal shift register: turns one accepted
// load/shift command into registered mode selects, fill bits and a done pulse.
module uni_shift_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_rot,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] reg_fb,
    output logic             s1,
    output logic             s0,
    output logic             MSB_in,
    output logic             LSB_in,
    output logic [WIDTH-1:0] reg_in,
    output logic             done,
    output logic             err
);

    state_e           state, state_next;
    sel_e             sel, sel_next;
    logic [WIDTH-1:0] reg_in_next;
    logic             done_next, err_next;
    op_e              op_q, cmd_op_e;
    logic             rot_q, fill_q, latch;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_q;
    logic             unused_fb_mid;

    assign cmd_op_e      = op_e'(cmd_op);
    assign unused_fb_mid = ^reg_fb[WIDTH-2:1];

    shift_cnt #(.CNT_W(CNT_W)) u_cnt (
        .CLK   (CLK),
        .clr   (clr),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .din   (cmd_cnt),
        .count (cnt_q),
        .zero  (cnt_zero)
    );

    // Outputs are registered from the next state so selects line up with the state they belong to.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_next  = state;
        sel_next    = SEL_HOLD;
        reg_in_next = '0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        latch       = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    latch = 1'b1;
                    case (cmd_op_e)
                        OP_LOAD: begin
                            state_next  = ST_LOAD;
                            sel_next    = SEL_LOAD;
                            reg_in_next = cmd_data;
                        end
                        OP_SHR, OP_SHL: begin
                            if (cmd_cnt != '0) begin
                                state_next = ST_SHIFT;
                                sel_next   = shift_sel(cmd_op_e);
                                cnt_load   = 1'b1;
                            end else begin
                                state_next = ST_DONE;
                                done_next  = 1'b1;
                            end
                        end
                        default: begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                            err_next   = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_next = ST_DONE;
                done_next  = 1'b1;
            end
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                if ((cnt_q == CNT_W'(1)) || cnt_zero) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    sel_next = shift_sel(op_q);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            state  <= ST_IDLE;
            sel    <= SEL_HOLD;
            reg_in <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            op_q   <= OP_LOAD;
            rot_q  <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            state  <= state_next;
            sel    <= sel_next;
            reg_in <= reg_in_next;
            done   <= done_next;
            err    <= err_next;
            if (latch) begin
                op_q   <= cmd_op_e;
                rot_q  <= cmd_rot;
                fill_q <= cmd_fill;
            end
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign s1        = sel[1];
    assign s0        = sel[0];

    // Rotate takes the bit falling off the opposite end of the live register.
    assign MSB_in = (state == ST_SHIFT) && (rot_q ? reg_fb[0]       : fill_q);
    assign LSB_in = (state == ST_SHIFT) && (rot_q ? reg_fb[WIDTH-1] : fill_q);

endmodule
